// File: rtl/periph_responder_pkg.sv
// Shared definitions for the memory-mapped peripheral responder: register offsets,
// CTRL bit positions, access FSM states and the captured-request record.
package periph_responder_pkg;

    localparam logic [7:0] OFS_LED    = 8'h00;
    localparam logic [7:0] OFS_CTRL   = 8'h04;
    localparam logic [7:0] OFS_LOAD   = 8'h08;
    localparam logic [7:0] OFS_VAL    = 8'h0C;
    localparam logic [7:0] OFS_STATUS = 8'h10;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0]  ofs;
        logic        wr;
        logic [31:0] dat;
    } req_t;

    // Word decode: the two byte-lane bits of the offset never select a register.
    function automatic logic ofs_is(input logic [7:0] ofs, input logic [7:0] reg_ofs);
        return (ofs & 8'hFC) == reg_ofs;
    endfunction

endpackage

// File: rtl/periph_timer.sv
// 32-bit down-counting timer with reload and sticky expiry flag (IE stored only with PERIPH_IRQ_EN).
// Latency: register writes take effect on the strobe edge; VAL steps once per cycle while enabled.
// Backpressure: none; write strobes are single-cycle and always accepted.
module periph_timer
    import periph_responder_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        ctrl_we,
    input  logic [1:0]  ctrl_wdat,
`ifdef PERIPH_IRQ_EN
    input  logic        ctrl_ie_wdat,
`endif
    input  logic        load_we,
    input  logic [31:0] load_wdat,
    input  logic        status_clr,
    output logic        en,
    output logic        auto_reload,
    output logic        ie,
    output logic [31:0] load,
    output logic [31:0] val,
    output logic        expired
);

    logic expire;

    assign expire = en && (val == 32'd0);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            load        <= '0;
            val         <= '0;
            expired     <= 1'b0;
        end else begin
            if (load_we) begin
                load <= load_wdat;
            end
            if (en) begin
                if (val == 32'd0) begin
                    if (auto_reload) begin
                        val <= load;
                    end else begin
                        en <= 1'b0;
                    end
                end else begin
                    val <= val - 32'd1;
                end
            end
            // A CTRL write overrides the free-running step; only a 0->1 enable restarts from LOAD.
            if (ctrl_we) begin
                en          <= ctrl_wdat[CTRL_EN];
                auto_reload <= ctrl_wdat[CTRL_AR];
                if (ctrl_wdat[CTRL_EN] && !en) begin
                    val <= load;
                end
            end
            // Expiry takes priority over a same-cycle clear.
            if (expire) begin
                expired <= 1'b1;
            end else if (status_clr) begin
                expired <= 1'b0;
            end
        end
    end

`ifdef PERIPH_IRQ_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ie <= 1'b0;
        end else if (ctrl_we) begin
            ie <= ctrl_ie_wdat;
        end
    end
`else
    assign ie = 1'b0;
`endif

endmodule

// File: rtl/periph_responder.sv
// Peripheral responder for a 256-byte window: LED register plus timer; optional irq via PERIPH_IRQ_EN.
// Latency: busy_per high WAIT_STATES+1 cycles per access; read data lands on the edge busy_per falls.
// Backpressure: busy_per; ld_mem during an access or outside the window is dropped, nothing queues.
module periph_responder
    import periph_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          WAIT_STATES = 1,
    parameter int          LED_W       = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             ld_mem,
    input  logic             mem_wr,
    input  logic [31:0]      addr_mem,
    input  logic [31:0]      din_mem,
    output logic             hit,
    output logic             busy_per,
    output logic [31:0]      dout_per,
    output logic [LED_W-1:0] out_leds
`ifdef PERIPH_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wait_cnt;
    req_t             req;
    logic             capture;
    logic             commit;
    logic             wr_commit;
    logic [31:0]      rd_dat;
    logic [LED_W-1:0] led_q;

    logic             tmr_en;
    logic             tmr_ar;
    logic             tmr_ie;
    logic [31:0]      tmr_load;
    logic [31:0]      tmr_val;
    logic             tmr_expired;

    assign hit = (addr_mem[31:8] == BASE_ADDR[31:8]);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        commit    = 1'b0;
        busy_per  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_mem && hit) begin
                    capture   = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                busy_per = 1'b1;
                if (wait_cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            req      <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                wait_cnt <= WAIT_INIT;
                req      <= '{ofs: addr_mem[7:0], wr: mem_wr, dat: din_mem};
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    assign wr_commit = commit && req.wr;

    periph_timer u_timer (
        .clock       (clock),
        .rst         (rst),
        .ctrl_we     (wr_commit && ofs_is(req.ofs, OFS_CTRL)),
        .ctrl_wdat   (req.dat[CTRL_AR:CTRL_EN]),
`ifdef PERIPH_IRQ_EN
        .ctrl_ie_wdat(req.dat[CTRL_IE]),
`endif
        .load_we     (wr_commit && ofs_is(req.ofs, OFS_LOAD)),
        .load_wdat   (req.dat),
        .status_clr  (wr_commit && ofs_is(req.ofs, OFS_STATUS) && req.dat[0]),
        .en          (tmr_en),
        .auto_reload (tmr_ar),
        .ie          (tmr_ie),
        .load        (tmr_load),
        .val         (tmr_val),
        .expired     (tmr_expired)
    );

    always_comb begin
        rd_dat = '0;
        if (ofs_is(req.ofs, OFS_LED)) begin
            rd_dat[LED_W-1:0] = led_q;
        end else if (ofs_is(req.ofs, OFS_CTRL)) begin
            rd_dat[CTRL_EN] = tmr_en;
            rd_dat[CTRL_AR] = tmr_ar;
            rd_dat[CTRL_IE] = tmr_ie;
        end else if (ofs_is(req.ofs, OFS_LOAD)) begin
            rd_dat = tmr_load;
        end else if (ofs_is(req.ofs, OFS_VAL)) begin
            rd_dat = tmr_val;
        end else if (ofs_is(req.ofs, OFS_STATUS)) begin
            rd_dat[0] = tmr_expired;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            dout_per <= '0;
            led_q    <= '0;
        end else begin
            if (commit && !req.wr) begin
                dout_per <= rd_dat;
            end
            if (wr_commit && ofs_is(req.ofs, OFS_LED)) begin
                led_q <= req.dat[LED_W-1:0];
            end
        end
    end

    assign out_leds = led_q;

`ifdef PERIPH_IRQ_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= tmr_expired & tmr_ie;
        end
    end
`endif

endmodule
